uart_debug_snap: RTL and testbench

Snapshot sequencer for the UART debug register mux. On a software pulse or a periodic timer it walks the debug mux address through the two debug words, captures them, and pushes one 64-bit snapshot into a small FIFO. The FIFO drains through a valid/ready port to a trace or logging consumer. It sits between the UART core's debug mux, which it owns and addresses, and any debug collector.

---
 rtl/uart_debug_snap.sv | 154 +++++++++++++++
 tb/tb_uart_debug_snap.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_snap.sv
// uart_debug_snap: walks the UART debug mux through two words on a
// software or periodic trigger and queues 64-bit snapshots in a FIFO.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-low reset
//   start_i              one-shot snapshot request (level, per cycle)
//   per_en_i, period_i   periodic trigger enable and interval (0 = off)
//   dbg_adr_o, dbg_dat_i debug mux address out, combinational data in
//   busy_o               sequencer not idle
//   snap_valid_o/data_o  FIFO head, {word1, word0}
//   snap_ready_i         consumer pops head when valid
//   snap_count_o         FIFO occupancy 0..DEPTH
//   drop_cnt_o           saturating count of snapshots lost to a full FIFO

module uart_debug_snap #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 3,
    parameter logic [4:0]  ADR0  = 5'h08,
    parameter logic [4:0]  ADR1  = 5'h0C
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic          per_en_i,
    input  logic [15:0]   period_i,
    output logic [4:0]    dbg_adr_o,
    input  logic [31:0]   dbg_dat_i,
    output logic          busy_o,
    output logic          snap_valid_o,
    output logic [63:0]   snap_data_o,
    input  logic          snap_ready_i,
    output logic [DW-1:0] snap_count_o,
    output logic [7:0]    drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_PUSH
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    adr_q, adr_d;
    logic          pend_q, pend_d;
    logic [31:0]   w0_q, w0_d;
    logic [31:0]   w1_q, w1_d;
    logic [15:0]   timer_q, timer_d;
    logic [7:0]    drop_q, drop_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [63:0]   mem_q [DEPTH];

    logic timer_run;
    logic timer_fire;
    logic trig;
    logic full;
    logic pop;
    logic push;

    assign snap_valid_o = (wptr_q != rptr_q);
    assign snap_data_o  = mem_q[rptr_q[AW-1:0]];
    assign snap_count_o = DW'(wptr_q - rptr_q);
    assign dbg_adr_o    = adr_q;
    assign busy_o       = (state_q != S_IDLE);
    assign drop_cnt_o   = drop_q;

    // Same low bits, different wrap bit: the writer is one lap ahead.
    assign full = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                  (wptr_q[AW] != rptr_q[AW]);
    assign pop  = snap_valid_o && snap_ready_i;

    // A shrunk period leaves count >= period-1, so it fires at once.
    assign timer_run  = per_en_i && (period_i != 16'd0);
    assign timer_fire = timer_run && (timer_q >= period_i - 16'd1);
    assign trig       = start_i || timer_fire;

    always_comb begin
        timer_d = (!timer_run || timer_fire) ? 16'd0 : timer_q + 16'd1;
        state_d = state_q;
        adr_d   = adr_q;
        pend_d  = pend_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        drop_d  = drop_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (trig || pend_q) begin
                    state_d = S_RD0;
                    adr_d   = ADR0;
                    // Pending request is consumed; a fresh one re-arms it.
                    pend_d  = pend_q && trig;
                end
            end
            S_RD0: begin
                if (trig) pend_d = 1'b1;
                w0_d    = dbg_dat_i;
                adr_d   = ADR1;
                state_d = S_RD1;
            end
            S_RD1: begin
                if (trig) pend_d = 1'b1;
                w1_d    = dbg_dat_i;
                adr_d   = 5'h00;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                if (trig) pend_d = 1'b1;
                if (!full || pop) begin
                    push = 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                state_d = S_IDLE;
            end
        endcase
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= 5'h00;
            pend_q  <= 1'b0;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            timer_q <= 16'h0;
            drop_q  <= 8'h0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'h0;
            end
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            pend_q  <= pend_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= {w1_q, w0_q};
            end
        end
    end

endmodule

// File: tb/tb_uart_debug_snap.sv
// tb_uart_debug_snap: directed bench for uart_debug_snap.
// Debug mux is modelled combinationally from dbg_adr_o.

module tb_uart_debug_snap;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        per_en;
    logic [15:0] period;
    logic [4:0]  dbg_adr;
    logic [31:0] dbg_dat;
    logic        busy;
    logic        valid;
    logic [63:0] data;
    logic        ready;
    logic [2:0]  count;
    logic [7:0]  drop;

    logic [31:0] w0;
    logic [31:0] w1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dbg_dat = (dbg_adr == 5'h08) ? w0 :
                     (dbg_adr == 5'h0C) ? w1 : 32'hDEAD_BEEF;

    uart_debug_snap dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .per_en_i     (per_en),
        .period_i     (period),
        .dbg_adr_o    (dbg_adr),
        .dbg_dat_i    (dbg_dat),
        .busy_o       (busy),
        .snap_valid_o (valid),
        .snap_data_o  (data),
        .snap_ready_i (ready),
        .snap_count_o (count),
        .drop_cnt_o   (drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        start  = 1'b0;
        per_en = 1'b0;
        period = 16'd0;
        ready  = 1'b0;
        stepn(2);
        rst = 1'b1;
    endtask

    // One trigger with tagged words; returns with the FSM back in IDLE.
    task automatic snap(input logic [15:0] id);
        w0    = {16'hA5A5, id};
        w1    = {16'h5A5A, id};
        start = 1'b1;
        step();
        start = 1'b0;
        stepn(4);
    endtask

    task automatic test_reset();
        w0 = 32'h0;
        w1 = 32'h0;
        do_reset();
        checks++;
        if (dbg_adr !== 5'h00) begin
            errors++;
            $display("FAIL reset_adr: got %h want 00", dbg_adr);
        end
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_valid: got %b%b want 00", busy, valid);
        end
        checks++;
        if (data !== 64'h0 || count !== 3'd0 || drop !== 8'd0) begin
            errors++;
            $display("FAIL reset_fifo: data %h count %0d drop %0d want 0",
                     data, count, drop);
        end
    endtask

    task automatic test_single();
        do_reset();
        w0    = 32'hA5A5_0001;
        w1    = 32'h0000_1234;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (dbg_adr !== 5'h08 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_adr0: got %h busy %b want 08 1", dbg_adr, busy);
        end
        step();
        checks++;
        if (dbg_adr !== 5'h0C) begin
            errors++;
            $display("FAIL single_adr1: got %h want 0c", dbg_adr);
        end
        step();
        checks++;
        if (dbg_adr !== 5'h00 || busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_push: adr %h busy %b valid %b want 00 1 0",
                     dbg_adr, busy, valid);
        end
        step();
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_valid: valid %b busy %b count %0d want 1 0 1",
                     valid, busy, count);
        end
        checks++;
        if (data !== 64'h0000_1234_A5A5_0001) begin
            errors++;
            $display("FAIL single_data: got %h want 00001234a5a50001", data);
        end
        stepn(3);
        checks++;
        if (data !== 64'h0000_1234_A5A5_0001 || valid !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: got %h valid %b", data, valid);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: valid %b count %0d want 0 0", valid, count);
        end
    endtask

    task automatic test_coalesce();
        int n;
        int at [4];
        logic [2:0] prev;
        do_reset();
        w0    = 32'h1111_0000;
        w1    = 32'h2222_0000;
        n     = 0;
        prev  = count;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) start = 1'b0;
            step();
            if (count != prev) begin
                if (n < 4) at[n] = c;
                n++;
                prev = count;
            end
        end
        checks++;
        if (n !== 2 || count !== 3'd2) begin
            errors++;
            $display("FAIL coalesce_num: pushes %0d count %0d want 2 2", n, count);
        end else begin
            checks++;
            if (at[0] !== 3 || at[1] !== 7) begin
                errors++;
                $display("FAIL coalesce_gap: at %0d %0d want 3 7", at[0], at[1]);
            end
        end
        checks++;
        if (drop !== 8'd0) begin
            errors++;
            $display("FAIL coalesce_drop: got %0d want 0", drop);
        end
    endtask

    task automatic test_periodic();
        int n;
        int v [3];
        int seen;
        do_reset();
        w0     = 32'h3333_0000;
        w1     = 32'h4444_0000;
        ready  = 1'b1;
        per_en = 1'b1;
        period = 16'd20;
        n      = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (valid === 1'b1) begin
                if (n < 3) v[n] = c;
                n++;
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL periodic_num: got %0d want 3", n);
        end else begin
            checks++;
            if (v[1] - v[0] !== 20 || v[2] - v[1] !== 20) begin
                errors++;
                $display("FAIL periodic_gap: got %0d %0d want 20 20",
                         v[1] - v[0], v[2] - v[1]);
            end
        end
        period = 16'd0;
        seen   = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (busy === 1'b1 || valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || dut.timer_q !== 16'd0) begin
            errors++;
            $display("FAIL periodic_off: activity %0d timer %0d want 0 0",
                     seen, dut.timer_q);
        end
        // Shrinking the period below the running count fires next cycle.
        do_reset();
        ready  = 1'b1;
        per_en = 1'b1;
        period = 16'd20;
        stepn(12);
        period = 16'd5;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL shrink_fire: busy %b want 1", busy);
        end
        stepn(3);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL shrink_snap: valid %b want 1", valid);
        end
        stepn(4);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL shrink_quiet: valid %b want 0", valid);
        end
        step();
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL shrink_next: valid %b want 1", valid);
        end
        per_en = 1'b0;
        period = 16'd0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) snap(16'(i));
        checks++;
        if (count !== 3'd4 || drop !== 8'd2) begin
            errors++;
            $display("FAIL ovf_count: count %0d drop %0d want 4 2", count, drop);
        end
        checks++;
        if (data !== 64'h5A5A_0001_A5A5_0001) begin
            errors++;
            $display("FAIL ovf_head: got %h want 5a5a0001a5a50001", data);
        end
        for (int i = 0; i < 300; i++) snap(16'(100 + i));
        checks++;
        if (drop !== 8'd255 || count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_sat: drop %0d count %0d want 255 4", drop, count);
        end
    endtask

    task automatic test_full_pop();
        logic [63:0] exp;
        do_reset();
        for (int i = 1; i <= 4; i++) snap(16'(i));
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_fill: count %0d want 4", count);
        end
        w0    = 32'hA5A5_0005;
        w1    = 32'h5A5A_0005;
        start = 1'b1;
        step();
        start = 1'b0;
        stepn(2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if (count !== 3'd4 || drop !== 8'd0) begin
            errors++;
            $display("FAIL full_pop: count %0d drop %0d want 4 0", count, drop);
        end
        for (int k = 2; k <= 5; k++) begin
            exp = {16'h5A5A, 16'(k), 16'hA5A5, 16'(k)};
            checks++;
            if (data !== exp || valid !== 1'b1) begin
                errors++;
                $display("FAIL full_order%0d: got %h want %h", k, data, exp);
            end
            ready = 1'b1;
            step();
        end
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain: valid %b count %0d want 0 0", valid, count);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        snap(16'h0077);
        w0    = 32'hA5A5_0088;
        w1    = 32'h5A5A_0088;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (dbg_adr !== 5'h00 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctl: adr %h busy %b valid %b want 00 0 0",
                     dbg_adr, busy, valid);
        end
        checks++;
        if (data !== 64'h0 || count !== 3'd0 || drop !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_fifo: data %h count %0d drop %0d want 0",
                     data, count, drop);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_quiet: activity %0d want 0", seen);
        end
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        per_en = 1'b0;
        period = 16'd0;
        ready  = 1'b0;
        w0     = 32'h0;
        w1     = 32'h0;
        test_reset();
        test_single();
        test_coalesce();
        test_periodic();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
